// File: rtl/ibex_l2_rf_pkg.sv
// Shared types and helpers for the L2 register-file scheduler.
// is_l2_addr decides which register indices live in the single-ported L2 array.
package ibex_l2_rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_A,
    RD_B,
    RESP
  } l2_sched_state_e;

  localparam int unsigned L1BaseDefault = 12;
  localparam int unsigned L1NumDefault  = 4;

  function automatic logic is_l2_addr(input logic [4:0] a, input int unsigned base,
                                      input int unsigned num);
    logic [31:0] w_a;
    w_a = {27'd0, a};
    return (a != 5'd0) && !((w_a >= base) && (w_a < base + num));
  endfunction

endpackage

// File: rtl/ibex_l2_rf_scheduler_if.sv
// Bus bundle between the ID/WB stages, the scheduler and the L2 array port.
// slave = scheduler view; master = core plus array side.
interface ibex_l2_rf_scheduler_if #(
  parameter int DataWidth = 32
);
  logic                 rd_req_i;
  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic                 rd_b_en_i;
  logic                 rd_valid_o;
  logic [DataWidth-1:0] rdata_a_o;
  logic [DataWidth-1:0] rdata_b_o;
  logic                 stall_o;
  logic                 wr_req_i;
  logic [4:0]           waddr_i;
  logic [DataWidth-1:0] wdata_i;
  logic                 wr_ready_o;
  logic [4:0]           l2_addr_o;
  logic                 l2_we_o;
  logic [DataWidth-1:0] l2_wdata_o;
  logic [DataWidth-1:0] l2_rdata_i;

  modport slave (
    input  rd_req_i, raddr_a_i, raddr_b_i, rd_b_en_i, wr_req_i, waddr_i, wdata_i, l2_rdata_i,
    output rd_valid_o, rdata_a_o, rdata_b_o, stall_o, wr_ready_o, l2_addr_o, l2_we_o, l2_wdata_o
  );

  modport master (
    output rd_req_i, raddr_a_i, raddr_b_i, rd_b_en_i, wr_req_i, waddr_i, wdata_i, l2_rdata_i,
    input  rd_valid_o, rdata_a_o, rdata_b_o, stall_o, wr_ready_o, l2_addr_o, l2_we_o, l2_wdata_o
  );

endinterface

// File: rtl/ibex_l2_rf_scheduler_wr_buf.sv
// One-entry L2 write-back buffer: accepts when empty or draining, and exposes
// its entry for forwarding into operand capture.
module ibex_l2_wr_buf #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_enq,
  input  logic [4:0]           i_enq_addr,
  input  logic [DataWidth-1:0] i_enq_data,
  input  logic                 i_drain_en,
  input  logic [4:0]           i_lkup_addr,
  output logic                 o_valid,
  output logic                 o_ready,
  output logic [4:0]           o_addr,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_fwd_hit,
  output logic [DataWidth-1:0] o_fwd_data
);

  logic                 r_valid;
  logic [4:0]           r_addr;
  logic [DataWidth-1:0] r_data;
  logic                 w_drain;

  assign w_drain = r_valid && i_drain_en;

  // Enqueue wins over drain so a same-cycle refill leaves the new entry behind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_enq) begin
      r_valid <= 1'b1;
      r_addr  <= i_enq_addr;
      r_data  <= i_enq_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_ready    = !r_valid || i_drain_en;
  assign o_addr     = r_addr;
  assign o_data     = r_data;
  assign o_fwd_hit  = r_valid && (r_addr == i_lkup_addr);
  assign o_fwd_data = r_data;

endmodule

// File: rtl/ibex_l2_rf_scheduler.sv
// Serialises up to two operand reads through the single L2 port and drains
// write-backs from a one-entry buffer whenever the port is not reading.
module ibex_l2_rf_scheduler
  import ibex_l2_rf_pkg::*;
#(
  parameter int          DataWidth = 32,
  parameter int unsigned L1Base    = L1BaseDefault,
  parameter int unsigned L1Num     = L1NumDefault
) (
  input logic                   clk_i,
  input logic                   rst_i,
  ibex_l2_rf_scheduler_if.slave bus
);

  l2_sched_state_e      r_state, w_state_nxt;
  logic [DataWidth-1:0] r_buf_a, r_buf_b;
  logic                 r_need_b, r_dup_b;

  logic                 w_need_a, w_need_b, w_dup_b;
  logic                 w_wr_is_l2, w_enq, w_drain_en;
  logic                 w_wb_valid, w_wb_ready, w_fwd_hit;
  logic [4:0]           w_wb_addr, w_rd_addr;
  logic [DataWidth-1:0] w_wb_data, w_fwd_data, w_cap;
  logic                 w_rd_valid, w_l2_we;
  logic [4:0]           w_l2_addr;
  logic [DataWidth-1:0] w_l2_wdata;

  assign w_need_a   = is_l2_addr(bus.raddr_a_i, L1Base, L1Num);
  assign w_dup_b    = bus.rd_b_en_i && w_need_a && (bus.raddr_b_i == bus.raddr_a_i);
  assign w_need_b   = bus.rd_b_en_i && is_l2_addr(bus.raddr_b_i, L1Base, L1Num) && !w_dup_b;

  // Non-L2 writes are acked unconditionally and never reach the buffer.
  assign w_wr_is_l2 = is_l2_addr(bus.waddr_i, L1Base, L1Num);
  assign w_drain_en = (r_state == IDLE) || (r_state == RESP);
  assign w_enq      = bus.wr_req_i && w_wr_is_l2 && w_wb_ready;
  assign w_rd_addr  = (r_state == RD_B) ? bus.raddr_b_i : bus.raddr_a_i;

  ibex_l2_wr_buf #(
    .DataWidth (DataWidth)
  ) u_wr_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_enq       (w_enq),
    .i_enq_addr  (bus.waddr_i),
    .i_enq_data  (bus.wdata_i),
    .i_drain_en  (w_drain_en),
    .i_lkup_addr (w_rd_addr),
    .o_valid     (w_wb_valid),
    .o_ready     (w_wb_ready),
    .o_addr      (w_wb_addr),
    .o_data      (w_wb_data),
    .o_fwd_hit   (w_fwd_hit),
    .o_fwd_data  (w_fwd_data)
  );

  // Youngest data wins: same-cycle write, then buffered write, then the array.
  always_comb begin
    w_cap = bus.l2_rdata_i;
    if (w_enq && (bus.waddr_i == w_rd_addr)) begin
      w_cap = bus.wdata_i;
    end else if (w_fwd_hit) begin
      w_cap = w_fwd_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_valid  = 1'b0;
    w_l2_we     = 1'b0;
    w_l2_addr   = '0;
    w_l2_wdata  = '0;
    unique case (r_state)
      IDLE: begin
        if (bus.rd_req_i) begin
          if (w_need_a)      w_state_nxt = RD_A;
          else if (w_need_b) w_state_nxt = RD_B;
          else               w_state_nxt = RESP;
        end
      end
      RD_A: begin
        w_l2_addr   = bus.raddr_a_i;
        w_state_nxt = r_need_b ? RD_B : RESP;
      end
      RD_B: begin
        w_l2_addr   = bus.raddr_b_i;
        w_state_nxt = RESP;
      end
      RESP: begin
        w_rd_valid  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_drain_en && w_wb_valid) begin
      w_l2_we    = 1'b1;
      w_l2_addr  = w_wb_addr;
      w_l2_wdata = w_wb_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_buf_a  <= '0;
      r_buf_b  <= '0;
      r_need_b <= 1'b0;
      r_dup_b  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (bus.rd_req_i) begin
            r_buf_a  <= '0;
            r_buf_b  <= '0;
            r_need_b <= w_need_b;
            r_dup_b  <= w_dup_b;
          end
        end
        RD_A: begin
          r_buf_a <= w_cap;
          // A duplicated B address goes RD_A -> RESP, so B takes A's value here.
          if (r_dup_b) r_buf_b <= w_cap;
        end
        RD_B:    r_buf_b <= w_cap;
        default: ;
      endcase
    end
  end

  assign bus.rd_valid_o = w_rd_valid;
  assign bus.stall_o    = bus.rd_req_i && !w_rd_valid;
  assign bus.rdata_a_o  = r_buf_a;
  assign bus.rdata_b_o  = r_buf_b;
  assign bus.wr_ready_o = !w_wr_is_l2 || w_wb_ready;
  assign bus.l2_addr_o  = w_l2_addr;
  assign bus.l2_we_o    = w_l2_we;
  assign bus.l2_wdata_o = w_l2_wdata;

  a_req_held : assert property (@(posedge clk_i) disable iff (rst_i)
    ((r_state == RD_A) || (r_state == RD_B)) |-> bus.rd_req_i);

endmodule

// File: tb/tb_ibex_l2_rf_scheduler.sv
// Directed bench for the L2 register-file scheduler with a behavioural L2 array.
module tb_ibex_l2_rf_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;
  logic [31:0] mem [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  ibex_l2_rf_scheduler_if #(.DataWidth(32)) bus ();

  ibex_l2_rf_scheduler #(.DataWidth(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.l2_rdata_i = mem[bus.l2_addr_o];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[5]  <= 32'hA5;
      mem[6]  <= 32'h66;
      mem[7]  <= 32'h77;
      mem[9]  <= 32'h99;
      mem[22] <= 32'h22;
    end else if (bus.l2_we_o) begin
      mem[bus.l2_addr_o] <= bus.l2_wdata_o;
    end
  end

  // Drives one read (optionally with a write in its first cycle) and reports what was seen.
  task automatic run_read(input logic [4:0] a, input logic [4:0] b, input logic ben,
                          input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                          output int lat, output logic [31:0] da, output logic [31:0] db,
                          output int stalls, output int nrd, output logic [4:0] ra0,
                          output logic [4:0] ra1);
    lat = -1; stalls = 0; nrd = 0; ra0 = '0; ra1 = '0; da = '0; db = '0;
    @(negedge clk);
    bus.rd_req_i = 1'b1; bus.raddr_a_i = a; bus.raddr_b_i = b; bus.rd_b_en_i = ben;
    bus.wr_req_i = wr; bus.waddr_i = wa; bus.wdata_i = wd;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        bus.wr_req_i = 1'b0;
      end
      #1;
      if (bus.stall_o) stalls++;
      if (!bus.l2_we_o && bus.l2_addr_o != 5'd0) begin
        if (nrd == 0) ra0 = bus.l2_addr_o; else ra1 = bus.l2_addr_o;
        nrd++;
      end
      if (bus.rd_valid_o) begin
        lat = k; da = bus.rdata_a_o; db = bus.rdata_b_o;
        break;
      end
    end
    @(negedge clk);
    bus.rd_req_i = 1'b0; bus.rd_b_en_i = 1'b0; bus.wr_req_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_init = 1'b1;
    bus.rd_req_i = 1'b1; bus.raddr_a_i = 5'd5; bus.raddr_b_i = 5'd7; bus.rd_b_en_i = 1'b1;
    bus.wr_req_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid_o); end
    n_tests++; if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", bus.stall_o); end
    n_tests++; if (bus.wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready_o); end
    n_tests++; if (bus.l2_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_l2_we got %b want 0", bus.l2_we_o); end
    n_tests++; if (bus.l2_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_l2_addr got %0d want 0", bus.l2_addr_o); end
    n_tests++; if (bus.l2_wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_l2_wdata got %h want 0", bus.l2_wdata_o); end
    n_tests++; if (bus.rdata_a_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_a got %h want 0", bus.rdata_a_o); end
    n_tests++; if (bus.rdata_b_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_b got %h want 0", bus.rdata_b_o); end
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0; bus.rd_req_i = 1'b0;
  endtask

  task automatic test_two_operand;
    int lat, st, nrd; logic [31:0] da, db; logic [4:0] r0, r1;
    run_read(5'd5, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0, lat, da, db, st, nrd, r0, r1);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL two_op_latency got %0d want 3", lat); end
    n_tests++; if (da !== 32'hA5) begin n_fail++; $display("FAIL two_op_rdata_a got %h want a5", da); end
    n_tests++; if (db !== 32'h77) begin n_fail++; $display("FAIL two_op_rdata_b got %h want 77", db); end
    n_tests++; if (st != 3) begin n_fail++; $display("FAIL two_op_stall_cycles got %0d want 3", st); end
    n_tests++; if (nrd != 2 || r0 !== 5'd5 || r1 !== 5'd7) begin n_fail++; $display("FAIL two_op_l2_reads got n=%0d %0d,%0d want n=2 5,7", nrd, r0, r1); end
  endtask

  task automatic test_l1_x0;
    int lat, st, nrd; logic [31:0] da, db; logic [4:0] r0, r1;
    run_read(5'd12, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, lat, da, db, st, nrd, r0, r1);
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL l1_latency got %0d want 1", lat); end
    n_tests++; if (da !== 32'h0 || db !== 32'h0) begin n_fail++; $display("FAIL l1_rdata got %h/%h want 0/0", da, db); end
    n_tests++; if (nrd != 0) begin n_fail++; $display("FAIL l1_l2_reads got %0d want 0", nrd); end
    n_tests++; if (st != 1) begin n_fail++; $display("FAIL l1_stall_cycles got %0d want 1", st); end
  endtask

  task automatic test_dup_addr;
    int lat, st, nrd; logic [31:0] da, db; logic [4:0] r0, r1;
    run_read(5'd6, 5'd6, 1'b1, 1'b0, 5'd0, 32'h0, lat, da, db, st, nrd, r0, r1);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL dup_latency got %0d want 2", lat); end
    n_tests++; if (da !== 32'h66 || db !== 32'h66) begin n_fail++; $display("FAIL dup_rdata got %h/%h want 66/66", da, db); end
    n_tests++; if (nrd != 1) begin n_fail++; $display("FAIL dup_l2_reads got %0d want 1", nrd); end
  endtask

  task automatic test_immediate;
    int lat, st, nrd; logic [31:0] da, db; logic [4:0] r0, r1;
    run_read(5'd9, 5'd5, 1'b0, 1'b0, 5'd0, 32'h0, lat, da, db, st, nrd, r0, r1);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL imm_latency got %0d want 2", lat); end
    n_tests++; if (nrd != 1 || r0 !== 5'd9) begin n_fail++; $display("FAIL imm_l2_reads got n=%0d a=%0d want n=1 a=9", nrd, r0); end
    n_tests++; if (da !== 32'h99 || db !== 32'h0) begin n_fail++; $display("FAIL imm_rdata got %h/%h want 99/0", da, db); end
  endtask

  task automatic test_forward;
    int lat, st, nrd; logic [31:0] da, db; logic [4:0] r0, r1;
    run_read(5'd9, 5'd12, 1'b1, 1'b1, 5'd9, 32'hDEAD, lat, da, db, st, nrd, r0, r1);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL fwd_latency got %0d want 2", lat); end
    n_tests++; if (da !== 32'hDEAD) begin n_fail++; $display("FAIL fwd_rdata_a got %h want dead", da); end
    n_tests++; if (mem[9] !== 32'hDEAD) begin n_fail++; $display("FAIL fwd_l2_x9 got %h want dead", mem[9]); end
  endtask

  task automatic test_drop_write;
    @(negedge clk);
    bus.wr_req_i = 1'b1; bus.waddr_i = 5'd13; bus.wdata_i = 32'h1234;
    #1;
    n_tests++; if (bus.wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL drop_wr_ready got %b want 1", bus.wr_ready_o); end
    @(negedge clk);
    bus.wr_req_i = 1'b0;
    #1;
    n_tests++; if (bus.l2_we_o !== 1'b0) begin n_fail++; $display("FAIL drop_l2_we got %b want 0", bus.l2_we_o); end
    n_tests++; if (mem[13] !== 32'h0) begin n_fail++; $display("FAIL drop_l2_x13 got %h want 0", mem[13]); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.rd_req_i = 1'b1; bus.raddr_a_i = 5'd5; bus.raddr_b_i = 5'd7; bus.rd_b_en_i = 1'b1;
    #1;
    @(negedge clk);
    bus.wr_req_i = 1'b1; bus.waddr_i = 5'd5; bus.wdata_i = 32'h5555;
    #1;
    n_tests++; if (bus.wr_ready_o !== 1'b1 || bus.l2_addr_o !== 5'd5) begin n_fail++; $display("FAIL b2b_rd_a got rdy=%b addr=%0d want rdy=1 addr=5", bus.wr_ready_o, bus.l2_addr_o); end
    @(negedge clk);
    bus.waddr_i = 5'd7; bus.wdata_i = 32'h7777;
    #1;
    n_tests++; if (bus.wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_second_ready got %b want 0", bus.wr_ready_o); end
    n_tests++; if (bus.l2_we_o !== 1'b0 || bus.l2_addr_o !== 5'd7) begin n_fail++; $display("FAIL b2b_rd_b got we=%b addr=%0d want we=0 addr=7", bus.l2_we_o, bus.l2_addr_o); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", bus.rd_valid_o); end
    n_tests++; if (bus.rdata_a_o !== 32'h5555 || bus.rdata_b_o !== 32'h77) begin n_fail++; $display("FAIL b2b_rdata got %h/%h want 5555/77", bus.rdata_a_o, bus.rdata_b_o); end
    n_tests++; if (bus.wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_resp_ready got %b want 1", bus.wr_ready_o); end
    n_tests++; if (bus.l2_we_o !== 1'b1 || bus.l2_addr_o !== 5'd5 || bus.l2_wdata_o !== 32'h5555) begin n_fail++; $display("FAIL b2b_drain1 got we=%b a=%0d d=%h want 1/5/5555", bus.l2_we_o, bus.l2_addr_o, bus.l2_wdata_o); end
    @(negedge clk);
    bus.rd_req_i = 1'b0; bus.wr_req_i = 1'b0;
    #1;
    n_tests++; if (bus.l2_we_o !== 1'b1 || bus.l2_addr_o !== 5'd7 || bus.l2_wdata_o !== 32'h7777) begin n_fail++; $display("FAIL b2b_drain2 got we=%b a=%0d d=%h want 1/7/7777", bus.l2_we_o, bus.l2_addr_o, bus.l2_wdata_o); end
    @(negedge clk);
    #1;
    n_tests++; if (bus.l2_we_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_we got %b want 0", bus.l2_we_o); end
    n_tests++; if (mem[5] !== 32'h5555 || mem[7] !== 32'h7777) begin n_fail++; $display("FAIL b2b_l2_contents got %h/%h want 5555/7777", mem[5], mem[7]); end
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    bus.rd_req_i = 1'b1; bus.raddr_a_i = 5'd5; bus.raddr_b_i = 5'd7; bus.rd_b_en_i = 1'b1;
    #1;
    @(negedge clk);
    bus.wr_req_i = 1'b1; bus.waddr_i = 5'd22; bus.wdata_i = 32'hBEEF;
    #1;
    n_tests++; if (bus.wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_enq_ready got %b want 1", bus.wr_ready_o); end
    @(negedge clk);
    bus.wr_req_i = 1'b0; bus.rd_req_i = 1'b0; rst = 1'b1;
    #1;
    n_tests++; if (bus.l2_we_o !== 1'b0 || bus.l2_addr_o !== 5'd7) begin n_fail++; $display("FAIL rst_mid_rd_b got we=%b addr=%0d want we=0 addr=7", bus.l2_we_o, bus.l2_addr_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (bus.rd_valid_o !== 1'b0 || bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got valid=%b stall=%b want 0/0", bus.rd_valid_o, bus.stall_o); end
    n_tests++; if (bus.l2_we_o !== 1'b0 || bus.l2_addr_o !== 5'd0 || bus.wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_wbuf got we=%b addr=%0d rdy=%b want 0/0/1", bus.l2_we_o, bus.l2_addr_o, bus.wr_ready_o); end
    @(negedge clk);
    #1;
    n_tests++; if (mem[22] !== 32'h22) begin n_fail++; $display("FAIL rst_mid_l2_x22 got %h want 22", mem[22]); end
  endtask

  initial begin
    test_reset();
    test_two_operand();
    test_l1_x0();
    test_dup_addr();
    test_immediate();
    test_forward();
    test_drop_write();
    test_back_to_back();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ibex_l2_rf_scheduler.md
# ibex_l2_rf_scheduler

Sequencing controller for the single-ported L2 register array (`ibex_l2_register_file`) behind the two-level register file. Serialises up to two operand reads per instruction through the one L2 port, with an explicit handshake and stall. Holds L2 write-backs in a 1-entry write buffer and forwards from it, draining the buffer whenever the port is idle. Sits between the ID/WB stages and the L2 array; the L1 registers (x12–x15) and x0 never touch it.

## Interface
Parameters:
- `DataWidth`, 32, register width.
- `L1Base`, 12, first L1-resident register index.
- `L1Num`, 4, number of L1-resident registers (`L1Base` .. `L1Base+L1Num-1`).

Ports:
- `clk_i`  in  1  clock. One clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `rd_req_i`  in  1  operand read request; held with addresses stable until `rd_valid_o`.
- `raddr_a_i`, `raddr_b_i`  in  5  operand addresses.
- `rd_b_en_i`  in  1  operand B used (0 for immediate instructions).
- `rd_valid_o`  out  1  one-cycle pulse; operands valid.
- `rdata_a_o`, `rdata_b_o`  out  DataWidth  L2 operand data; 0 for non-L2 operands.
- `stall_o`  out  1  `rd_req_i && !rd_valid_o`.
- `wr_req_i`  in  1  write-back request.
- `waddr_i`  in  5  write address.
- `wdata_i`  in  DataWidth  write data.
- `wr_ready_o`  out  1  write accepted this cycle when high with `wr_req_i`.
- `l2_addr_o`  out  5  L2 array address.
- `l2_we_o`  out  1  L2 write enable.
- `l2_wdata_o`  out  DataWidth  L2 write data.
- `l2_rdata_i`  in  DataWidth  L2 read data, combinational from `l2_addr_o`.

## Operation
- `is_l2(a)`: `a != 0` and `a` outside `[L1Base, L1Base+L1Num)`. Writes with `!is_l2(waddr_i)` are accepted (`wr_ready_o=1`) and dropped.
- FSM states: IDLE, RD_A, RD_B, RESP.
- IDLE, `rd_req_i=1`:
  - `need_a = is_l2(raddr_a_i)`; `need_b = rd_b_en_i && is_l2(raddr_b_i) && !(need_a && raddr_b_i==raddr_a_i)`.
  - Next state: RD_A if `need_a`, else RD_B if `need_b`, else RESP. Non-L2 operand buffers are cleared to 0.
- RD_A: `l2_addr_o=raddr_a_i`; capture into buffer A. Next: RD_B if `need_b`, else RESP.
- RD_B: `l2_addr_o=raddr_b_i`; capture into buffer B. Next: RESP. If B shares A's address, B is copied from buffer A at RESP entry.
- RESP: `rd_valid_o=1` for one cycle; outputs driven from the buffers. Next: IDLE. A request still high in IDLE is treated as a new instruction.
- Capture source, highest priority first:
  1. incoming accepted write with matching address (same cycle);
  2. valid write-buffer entry with matching address;
  3. `l2_rdata_i`.
- Write buffer (1 entry: valid, addr, data):
  - Drains (`l2_we_o=1`, `l2_addr_o`/`l2_wdata_o` from the entry) in any cycle whose state is IDLE or RESP.
  - `wr_ready_o = !valid || drain_this_cycle`.
  - Enqueue and drain in the same cycle are legal; the buffer holds the new entry afterwards.
- `l2_we_o=0` in RD_A and RD_B; `l2_addr_o=0` when the port is unused.

## Timing
- Read latency from the `rd_req_i` cycle in IDLE (cycle 0): `rd_valid_o` in cycle 1 with no L2 reads, cycle 2 with one, cycle 3 with two.
- `stall_o` high for 1/2/3 cycles correspondingly; low in the `rd_valid_o` cycle.
- Write drain occurs at the earliest IDLE/RESP cycle after enqueue; worst case 2 cycles of RD_A/RD_B blocking.
- Reset values: state IDLE, buffers 0, write buffer invalid.
  - Outputs: `rd_valid_o=0`, `stall_o=rd_req_i`, `wr_ready_o=1`, `l2_we_o=0`, `l2_addr_o=0`, `l2_wdata_o=0`, `rdata_*_o=0`.
- Reset mid-read abandons the request; reset with a pending write discards it.
- `rd_req_i` dropped before `rd_valid_o` is illegal; flagged by an assertion.

## Structure
- Package `ibex_l2_rf_pkg` holds:
  - state enum `l2_sched_state_e`;
  - `L1Base`/`L1Num` defaults;
  - function `is_l2_addr`.
- Sub-module `ibex_l2_wr_buf` is the 1-entry buffer, containing enqueue/drain handshake and the forward compare/data outputs.
- FSM and capture muxing live in the top module.

## Test plan
- Read x5 and x7 (L2 holds 0xA5, 0x77) -> `rd_valid_o` at cycle 3, `rdata_a_o=0xA5`, `rdata_b_o=0x77`, `stall_o` high cycles 0–2.
- Read x12 and x0 -> `rd_valid_o` at cycle 1, both rdata 0, no L2 access.
- Immediate instruction (`rd_b_en_i=0`), A=x9 -> valid at cycle 2, single L2 read of address 9.
- Write x9=0xDEAD, then read x9 while the entry is still buffered -> `rdata_a_o=0xDEAD` via forwarding; L2 x9=0xDEAD after drain.
- Two back-to-back writes during a two-operand read -> second write sees `wr_ready_o=0` until the RESP-cycle drain; both land in L2 in order.
- Assert `rst_i` in RD_B with a pending write -> next cycle IDLE, `rd_valid_o=0`, buffer invalid, L2 unchanged.
